cisr_row_len_buffer: RTL and testbench

//  Shared row-length FIFO for CISR SpMV, sitting directly upstream of the CISR row decoder.
//  It accepts a packed stream of row lengths (CISR order) from the memory fetch path.

---
 rtl/cisr_row_len_buffer.sv | 136 +++++++++++++
 tb/tb_cisr_row_len_buffer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/cisr_row_len_buffer.sv
// Shared row-length FIFO feeding the CISR row decoder: packed beats in, one entry
// per requesting channel out, lowest channel takes the oldest entry.

module cisr_rlb_ch #(
    parameter int AW    = 6,
    parameter int DIM_W = 16
) (
    input  logic             pop,
    input  logic [DIM_W-1:0] prefix,
    input  logic [DIM_W-1:0] avail,
    input  logic [AW-1:0]    head,
    output logic             grant,
    output logic [AW-1:0]    rd_idx
);
    // Requesters ahead of this one take the first 'prefix' entries.
    assign grant  = pop && (prefix < avail);
    assign rd_idx = head + prefix[AW-1:0];
endmodule

module cisr_row_len_buffer #(
    parameter int NUM_CH   = 16,
    parameter int DATA_W   = 32,
    parameter int IN_LANES = 4,
    parameter int DEPTH    = 64,
    parameter int DIM_W    = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             spmv_init,
    input  logic [DIM_W-1:0]                 num_rows,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [IN_LANES*DATA_W-1:0]       in_data,
    input  logic [$clog2(IN_LANES):0]        in_cnt,
    input  logic [NUM_CH-1:0]                row_len_pop,
    output logic [NUM_CH-1:0][DATA_W-1:0]    row_len,
    output logic [NUM_CH-1:0]                pipe_bubble,
    output logic                             done
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;
    localparam int CW = $clog2(IN_LANES) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state_q, state_d;
    logic [AW-1:0]        head_q, tail_q;
    logic [OW-1:0]        occ_q, space, acc_cnt;
    logic [DIM_W-1:0]     disp_q, rows_q, remain, avail, consumed;
    logic                 done_q, wr_en;
    logic [DATA_W-1:0]    mem [DEPTH];

    logic [NUM_CH:0][DIM_W-1:0] prefix;
    logic [NUM_CH-1:0]          grant;
    logic [NUM_CH-1:0][AW-1:0]  rd_idx;

    assign space    = OW'(DEPTH) - occ_q;
    assign in_ready = (state_q == RUN) && (space >= OW'(IN_LANES));
    // A beat offered in the init cycle belongs to the old matrix and is dropped.
    assign wr_en    = in_valid && in_ready && !spmv_init;
    assign acc_cnt  = wr_en ? OW'(in_cnt) : '0;

    assign remain = rows_q - disp_q;
    always_comb begin
        avail = '0;
        if (state_q == RUN && !spmv_init)
            avail = (DIM_W'(occ_q) < remain) ? DIM_W'(occ_q) : remain;
    end

    always_comb begin
        prefix    = '0;
        for (int k = 0; k < NUM_CH; k++)
            prefix[k+1] = prefix[k] + DIM_W'(row_len_pop[k]);
    end

    // Grants are a contiguous run in request order, so the count is a simple clip.
    assign consumed = (prefix[NUM_CH] < avail) ? prefix[NUM_CH] : avail;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        cisr_rlb_ch #(.AW(AW), .DIM_W(DIM_W)) u_ch (
            .pop    (row_len_pop[k]),
            .prefix (prefix[k]),
            .avail  (avail),
            .head   (head_q),
            .grant  (grant[k]),
            .rd_idx (rd_idx[k])
        );
        assign row_len[k]     = grant[k] ? mem[rd_idx[k]] : '0;
        assign pipe_bubble[k] = (state_q == IDLE || spmv_init) ? 1'b1
                                                               : (row_len_pop[k] && !grant[k]);
    end

    always_comb begin
        state_d = state_q;
        if (spmv_init)
            state_d = (num_rows != '0) ? RUN : DONE;
        else if (state_q == RUN && (disp_q + consumed) == rows_q)
            state_d = DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            occ_q   <= '0;
            disp_q  <= '0;
            rows_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_d == DONE);
            if (spmv_init) begin
                head_q <= '0;
                tail_q <= '0;
                occ_q  <= '0;
                disp_q <= '0;
                rows_q <= num_rows;
            end else begin
                head_q <= head_q + consumed[AW-1:0];
                tail_q <= tail_q + acc_cnt[AW-1:0];
                occ_q  <= occ_q + acc_cnt - OW'(consumed);
                disp_q <= disp_q + consumed;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            for (int i = 0; i < IN_LANES; i++)
                if (CW'(i) < in_cnt)
                    mem[tail_q + AW'(i)] <= in_data[i*DATA_W +: DATA_W];
    end

    assign done = done_q;
endmodule

// File: tb/tb_cisr_row_len_buffer.sv
// Directed bench for cisr_row_len_buffer: hand-computed grants, bubbles, full/wrap and re-init.

module tb_cisr_row_len_buffer;
    localparam int NUM_CH = 16, DATA_W = 32, IN_LANES = 4, DEPTH = 64, DIM_W = 16;

    logic                          clk = 0;
    logic                          rst_n = 0;
    logic                          spmv_init = 0;
    logic [DIM_W-1:0]              num_rows = '0;
    logic                          in_valid = 0;
    logic                          in_ready;
    logic [IN_LANES*DATA_W-1:0]    in_data = '0;
    logic [$clog2(IN_LANES):0]     in_cnt = '0;
    logic [NUM_CH-1:0]             row_len_pop = '0;
    logic [NUM_CH-1:0][DATA_W-1:0] row_len;
    logic [NUM_CH-1:0]             pipe_bubble;
    logic                          done;

    int n_cmp = 0, n_err = 0;
    int wr_seq = 0, rd_seq = 0;

    cisr_row_len_buffer #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .IN_LANES(IN_LANES),
                          .DEPTH(DEPTH), .DIM_W(DIM_W)) dut (
        .clk(clk), .rst_n(rst_n), .spmv_init(spmv_init), .num_rows(num_rows),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_cnt(in_cnt),
        .row_len_pop(row_len_pop), .row_len(row_len), .pipe_bubble(pipe_bubble), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (rst_n && in_valid && in_ready)
            assert (in_cnt != 0) else $error("in_cnt of zero on accepted beat");

    initial begin
        #500000;
        $display("FAIL timeout: sim time exceeded bound");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic init(input int n);
        spmv_init = 1;
        num_rows  = DIM_W'(n);
        #3;
        chk("init_bubble", pipe_bubble, 16'hFFFF);
        step();
        spmv_init = 0;
    endtask

    task automatic push(input int cnt, input int v0, input int v1, input int v2, input int v3);
        in_valid = 1;
        in_cnt   = 3'(cnt);
        in_data  = {32'(v3), 32'(v2), 32'(v1), 32'(v0)};
        #3;
        chk("push_rdy", in_ready, 1);
        step();
        in_valid = 0;
    endtask

    task automatic push_seq(input int cnt);
        push(cnt, wr_seq + 1, wr_seq + 2, wr_seq + 3, wr_seq + 4);
        wr_seq += cnt;
    endtask

    // Pop the low n channels; expect them all granted with the next in-order entries.
    task automatic pop_seq(input int n);
        row_len_pop = 16'((32'h1 << n) - 1);
        #3;
        for (int k = 0; k < n; k++) chk("seq_row", row_len[k], 64'(rd_seq + 1 + k));
        chk("seq_bubble", pipe_bubble, 0);
        rd_seq += n;
        step();
        row_len_pop = '0;
    endtask

    initial begin
        int exp8 [8] = '{3, 1, 4, 1, 5, 9, 2, 6};
        #3;
        chk("rst_rdy", in_ready, 0);
        chk("rst_bubble", pipe_bubble, 16'hFFFF);
        chk("rst_done", done, 0);
        chk("rst_row0", row_len[0], 0);
        step();
        step();
        rst_n = 1;
        step();
        chk("idle_bubble", pipe_bubble, 16'hFFFF);

        // Two full beats then pop all eight at once.
        init(8);
        chk("run_rdy", in_ready, 1);
        push(4, 3, 1, 4, 1);
        push(4, 5, 9, 2, 6);
        row_len_pop = 16'h00FF;
        #3;
        for (int k = 0; k < 8; k++) chk("t2_row", row_len[k], 64'(exp8[k]));
        chk("t2_bubble", pipe_bubble, 0);
        step();
        row_len_pop = '0;
        #3;
        chk("t2_done", done, 1);
        chk("t2_rdy", in_ready, 0);
        step();

        // Partial service: two entries, three requesters.
        init(100);
        push(2, 7, 8, 0, 0);
        row_len_pop = 16'h0111;
        #3;
        chk("t3_ch0", row_len[0], 7);
        chk("t3_ch4", row_len[4], 8);
        chk("t3_ch8", row_len[8], 0);
        chk("t3_bubble", pipe_bubble, 16'h0100);
        step();
        row_len_pop = 16'h0001;
        #3;
        chk("t3_empty", pipe_bubble, 16'h0001);
        chk("t3_done", done, 0);
        step();
        row_len_pop = '0;

        // Fill to 62, drain 48, refill to 60, pop+write together, then wrap head.
        init(1000);
        wr_seq = 0;
        rd_seq = 0;
        for (int b = 0; b < 15; b++) push_seq(4);
        #3;
        chk("t4_rdy60", in_ready, 1);
        push_seq(2);
        #3;
        chk("t4_full62", in_ready, 0);
        step();
        for (int p = 0; p < 3; p++) pop_seq(16);
        for (int b = 0; b < 11; b++) push_seq(4);
        push_seq(2);
        row_len_pop = 16'h000F;
        in_valid = 1;
        in_cnt   = 3'd4;
        in_data  = {32'(wr_seq + 4), 32'(wr_seq + 3), 32'(wr_seq + 2), 32'(wr_seq + 1)};
        #3;
        chk("t4_sim_rdy", in_ready, 1);
        for (int k = 0; k < 4; k++) chk("t4_sim_row", row_len[k], 64'(rd_seq + 1 + k));
        wr_seq += 4;
        rd_seq += 4;
        step();
        in_valid = 0;
        row_len_pop = '0;
        #3;
        chk("t4_occ60_rdy", in_ready, 1);
        pop_seq(16);
        pop_seq(16);

        // End clip: only five rows remain for eight requesters.
        init(5);
        push(4, 10, 11, 12, 13);
        push(4, 14, 15, 16, 17);
        row_len_pop = 16'h00FF;
        #3;
        for (int k = 0; k < 5; k++) chk("t5_row", row_len[k], 64'(10 + k));
        chk("t5_row5", row_len[5], 0);
        chk("t5_bubble", pipe_bubble, 16'h00E0);
        step();
        row_len_pop = 16'h0001;
        #3;
        chk("t5_done", done, 1);
        chk("t5_rdy", in_ready, 0);
        chk("t5_done_bubble", pipe_bubble, 16'h0001);
        step();
        row_len_pop = '0;

        // Re-init with ten entries buffered discards them.
        init(100);
        push(4, 20, 21, 22, 23);
        push(4, 24, 25, 26, 27);
        push(2, 28, 29, 0, 0);
        row_len_pop = 16'hFFFF;
        init(3);
        row_len_pop = 16'h0001;
        #3;
        chk("t6_empty", pipe_bubble, 16'h0001);
        chk("t6_rdy", in_ready, 1);
        chk("t6_done", done, 0);
        step();
        row_len_pop = '0;
        push(3, 40, 41, 42, 0);
        row_len_pop = 16'h000F;
        #3;
        for (int k = 0; k < 3; k++) chk("t6_row", row_len[k], 64'(40 + k));
        chk("t6_bubble", pipe_bubble, 16'h0008);
        step();
        row_len_pop = '0;
        #3;
        chk("t6_done1", done, 1);
        step();

        // Asynchronous reset mid-run.
        init(50);
        push(4, 1, 2, 3, 4);
        row_len_pop = 16'h0001;
        #2;
        rst_n = 0;
        #1;
        chk("t1_rdy", in_ready, 0);
        chk("t1_bubble", pipe_bubble, 16'hFFFF);
        chk("t1_done", done, 0);
        chk("t1_row0", row_len[0], 0);
        step();
        row_len_pop = '0;
        rst_n = 1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
